bist_march_ctrl: RTL and testbench

//  Self-contained March C- BIST sequencer for one single-port synchronous SRAM.

---
 rtl/bist_march_if.sv | 30 +++
 rtl/bist_march_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_bist_march_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/bist_march_if.sv
// BIST controller bus: test-controller handshake plus the single-port SRAM strobes.
// The master modport is the BIST sequencer side, the slave modport is the controller/memory side.
interface bist_march_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
);
  logic          start;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  start, mem_rdata,
    output busy, done, fail, fail_addr, fail_elem,
           mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    output start, mem_rdata,
    input  busy, done, fail, fail_addr, fail_elem,
           mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/bist_march_ctrl.sv
// March C- BIST sequencer for one single-port synchronous SRAM: address/strobe sequencing,
// background data, one-cycle-delayed read compare and first-failure logging.
module bist_march_ctrl #(
  parameter int unsigned AW           = 4,
  parameter int unsigned DW           = 8,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  bist_march_if.master bist_io
);

  localparam logic [AW-1:0] ADDR_LAST = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          phase_q, phase_d;
  logic          rd_pend_q, rd_pend_d;
  logic [DW-1:0] exp_q, exp_d;
  logic [AW-1:0] cmp_addr_q, cmp_addr_d;
  logic [2:0]    cmp_elem_q, cmp_elem_d;
  logic          fail_q, fail_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]    fail_elem_q, fail_elem_d;

  logic          busy_c;
  logic          re_c;
  logic          we_c;
  logic [DW-1:0] wdata_c;
  logic [DW-1:0] exp_c;
  logic [2:0]    elem_c;
  logic          mismatch_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      rd_pend_q   <= rd_pend_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  always_comb begin
    // Strobe/background decode from registered state and phase (phase 0 = read, 1 = write)
    re_c    = 1'b0;
    we_c    = 1'b0;
    wdata_c = '0;
    exp_c   = '0;
    elem_c  = 3'd0;
    busy_c  = (state_q != S_IDLE) && (state_q != S_DONE);
    case (state_q)
      S_M0: we_c = 1'b1;
      S_M1, S_M3: begin
        elem_c  = (state_q == S_M1) ? 3'd1 : 3'd3;
        re_c    = !phase_q;
        we_c    = phase_q;
        wdata_c = '1;
      end
      S_M2, S_M4: begin
        elem_c = (state_q == S_M2) ? 3'd2 : 3'd4;
        re_c   = !phase_q;
        we_c   = phase_q;
        exp_c  = '1;
      end
      S_M5: begin
        elem_c = 3'd5;
        re_c   = 1'b1;
      end
      default: ;
    endcase

    mismatch_c = busy_c && rd_pend_q && (bist_io.mem_rdata != exp_q);

    state_d     = state_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    rd_pend_d   = re_c;
    exp_d       = exp_c;
    cmp_addr_d  = addr_q;
    cmp_elem_d  = elem_c;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bist_io.start) begin
          state_d     = S_M0;
          addr_d      = '0;
          phase_d     = 1'b0;
          rd_pend_d   = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = 3'd0;
        end
      end
      S_M0: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_M1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_M1, S_M2: begin
        phase_d = !phase_q;
        if (phase_q) begin
          if (addr_q == ADDR_LAST) begin
            state_d = (state_q == S_M1) ? S_M2 : S_M3;
            addr_d  = (state_q == S_M1) ? '0 : ADDR_LAST;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      S_M3, S_M4: begin
        phase_d = !phase_q;
        if (phase_q) begin
          if (addr_q == '0) begin
            state_d = (state_q == S_M3) ? S_M4 : S_M5;
            addr_d  = (state_q == S_M3) ? ADDR_LAST : '0;
          end else begin
            addr_d = addr_q - AW'(1);
          end
        end
      end
      S_M5: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        addr_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
        phase_d = 1'b0;
      end
    endcase

    // First mismatch wins; the write already on the bus this cycle still completes
    if (mismatch_c && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = cmp_addr_q;
      fail_elem_d = cmp_elem_q;
    end
    if (STOP_ON_FAIL && mismatch_c) begin
      state_d   = S_DONE;
      addr_d    = '0;
      phase_d   = 1'b0;
      rd_pend_d = 1'b0;
    end
  end

  assign bist_io.busy      = busy_c;
  assign bist_io.done      = (state_q == S_DONE);
  assign bist_io.fail      = fail_q;
  assign bist_io.fail_addr = fail_addr_q;
  assign bist_io.fail_elem = fail_elem_q;
  assign bist_io.mem_addr  = busy_c ? addr_q : '0;
  assign bist_io.mem_re    = re_c;
  assign bist_io.mem_we    = we_c;
  assign bist_io.mem_wdata = wdata_c;

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Directed bench for bist_march_ctrl: two instances (run-to-completion and stop-on-fail),
// each with a behavioural SRAM that can inject stuck-at and coupling-style read faults.
module tb_bist_march_ctrl;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr_cnt = 1'b0;
  always #5 clk = ~clk;

  bist_march_if #(.AW(AW), .DW(DW)) if0 ();
  bist_march_if #(.AW(AW), .DW(DW)) if1 ();

  bist_march_ctrl #(.AW(AW), .DW(DW), .STOP_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bist_io(if0.master));
  bist_march_ctrl #(.AW(AW), .DW(DW), .STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bist_io(if1.master));

  // Fault modes: 0 none, 1 bit0 stuck-1 @5, 2 bit0 stuck-0 @3, 3 flip on 5th read of @15
  int fault0 = 0;
  int fault1 = 0;
  int rd0, wr0, n15_0, rd1, wr1, n15_1;
  logic [DW-1:0] mem0 [16];
  logic [DW-1:0] mem1 [16];

  function automatic logic [DW-1:0] rd_fault(input int mode, input logic [AW-1:0] a,
                                             input logic [DW-1:0] d, input int n15);
    logic [DW-1:0] r;
    r = d;
    if (mode == 1 && a == AW'(5)) r = d | DW'(1);
    if (mode == 2 && a == AW'(3)) r = d & ~DW'(1);
    if (mode == 3 && a == AW'(15) && n15 == 4) r = ~d;
    return r;
  endfunction

  always @(posedge clk) begin
    if (clr_cnt) begin
      rd0 <= 0; wr0 <= 0; n15_0 <= 0;
    end else begin
      if (if0.mem_we) begin
        mem0[if0.mem_addr] <= if0.mem_wdata;
        wr0 <= wr0 + 1;
      end
      if (if0.mem_re) begin
        if0.mem_rdata <= rd_fault(fault0, if0.mem_addr, mem0[if0.mem_addr], n15_0);
        rd0 <= rd0 + 1;
        if (if0.mem_addr == AW'(15)) n15_0 <= n15_0 + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (clr_cnt) begin
      rd1 <= 0; wr1 <= 0; n15_1 <= 0;
    end else begin
      if (if1.mem_we) begin
        mem1[if1.mem_addr] <= if1.mem_wdata;
        wr1 <= wr1 + 1;
      end
      if (if1.mem_re) begin
        if1.mem_rdata <= rd_fault(fault1, if1.mem_addr, mem1[if1.mem_addr], n15_1);
        rd1 <= rd1 + 1;
        if (if1.mem_addr == AW'(15)) n15_1 <= n15_1 + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] log_addr [400];
  logic          log_re   [400];
  logic          log_we   [400];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start dut0 and follow it while busy; optionally re-pulse start at busy cycle restart_at
  task automatic run0(input int restart_at, output int cyc, output logic fail_first,
                      output logic fail_last);
    if0.start = 1'b1;
    clr_cnt   = 1'b1;
    tick();
    if0.start = 1'b0;
    clr_cnt   = 1'b0;
    cyc = 0;
    fail_first = 1'b1;
    fail_last  = 1'b1;
    while (if0.busy && cyc < 400) begin
      log_addr[cyc] = if0.mem_addr;
      log_re[cyc]   = if0.mem_re;
      log_we[cyc]   = if0.mem_we;
      if (cyc == 0) fail_first = if0.fail;
      fail_last = if0.fail;
      if0.start = (cyc == restart_at);
      cyc++;
      tick();
    end
    if0.start = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic ff, fl;
    int   bad;
    int   strobes;

    if0.start = 1'b0;
    if1.start = 1'b0;
    tick();
    tick();
    check("reset_flags", {if0.busy, if0.done, if0.fail, if0.mem_re, if0.mem_we}, 0);
    check("reset_fields", {if0.fail_addr, if0.fail_elem, if0.mem_addr, if0.mem_wdata}, 0);
    rst = 1'b1;
    tick();
    check("idle_no_start", {if0.busy, if0.done}, 0);

    // Fault-free run
    fault0 = 0;
    run0(-1, cyc, ff, fl);
    check("clean_busy_cycles", cyc, 161);
    check("clean_done", if0.done, 1);
    check("clean_fail", if0.fail, 0);
    check("clean_fail_elem", if0.fail_elem, 0);
    check("clean_reads", rd0, 80);
    check("clean_writes", wr0, 80);
    check("done_quiet", {if0.mem_re, if0.mem_we, if0.mem_addr}, 0);

    // Address/strobe sequence of the fault-free run
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (!(log_we[i] && !log_re[i] && log_addr[i] == AW'(i))) bad++;
    check("m0_up_seq", bad, 0);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      int i = 16 + 2 * k;
      logic [AW-1:0] ea = AW'(k % 16);
      if (!(log_re[i] && !log_we[i] && log_addr[i] == ea &&
            log_we[i+1] && !log_re[i+1] && log_addr[i+1] == ea)) bad++;
    end
    check("m1m2_up_rw_pairs", bad, 0);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      int i = 80 + 2 * k;
      logic [AW-1:0] ea = AW'(15 - (k % 16));
      if (!(log_re[i] && !log_we[i] && log_addr[i] == ea &&
            log_we[i+1] && !log_re[i+1] && log_addr[i+1] == ea)) bad++;
    end
    check("m3m4_down_rw_pairs", bad, 0);
    bad = 0;
    for (int j = 0; j < 16; j++)
      if (!(log_re[144+j] && !log_we[144+j] && log_addr[144+j] == AW'(j))) bad++;
    if (log_re[160] || log_we[160]) bad++;
    check("m5_up_and_drain", bad, 0);

    // Stuck-at-1 bit0 at address 5: caught in M1, run continues
    fault0 = 1;
    run0(-1, cyc, ff, fl);
    check("sa1_busy_cycles", cyc, 161);
    check("sa1_fail", if0.fail, 1);
    check("sa1_fail_addr", if0.fail_addr, 5);
    check("sa1_fail_elem", if0.fail_elem, 1);
    check("sa1_done", if0.done, 1);

    // Fault visible only in the final M5 read of address 15: logged during DRAIN
    fault0 = 3;
    run0(-1, cyc, ff, fl);
    check("start_clears_fail", ff, 0);
    check("cpl_not_during_busy", fl, 0);
    check("cpl_busy_cycles", cyc, 161);
    check("cpl_fail", if0.fail, 1);
    check("cpl_fail_addr", if0.fail_addr, 15);
    check("cpl_fail_elem", if0.fail_elem, 5);

    // Stop-on-fail instance, stuck-at-0 bit0 at address 3: first miss in M2
    fault1 = 2;
    if1.start = 1'b1;
    clr_cnt   = 1'b1;
    tick();
    if1.start = 1'b0;
    clr_cnt   = 1'b0;
    cyc = 0;
    while (if1.busy && cyc < 400) begin
      cyc++;
      tick();
    end
    check("sof_busy_cycles", cyc, 56);
    check("sof_done", if1.done, 1);
    check("sof_fail_flag_elem_addr", {if1.fail, if1.fail_elem, if1.fail_addr}, {1'b1, 3'd2, 4'd3});
    check("sof_writes", wr1, 36);
    check("sof_reads", rd1, 20);
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      if (if1.mem_re || if1.mem_we) strobes++;
      tick();
    end
    check("sof_quiet_after_done", strobes, 0);

    // Asynchronous reset at cycle 50 of a faulty run
    fault0 = 1;
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    check("pre_reset_busy_fail", {if0.busy, if0.fail}, 2'b11);
    rst = 1'b0;
    #1;
    check("async_rst_flags", {if0.busy, if0.done, if0.fail, if0.mem_re, if0.mem_we}, 0);
    check("async_rst_fields", {if0.fail_addr, if0.fail_elem, if0.mem_addr, if0.mem_wdata}, 0);
    #2;
    rst = 1'b1;
    tick();
    check("post_rst_idle", {if0.busy, if0.done, if0.fail}, 0);

    // Start during busy ignored; restart from DONE clears fail and reruns fully
    run0(20, cyc, ff, fl);
    check("restart_ignored_cycles", cyc, 161);
    check("restart_ignored_fail", {if0.done, if0.fail, if0.fail_elem}, {1'b1, 1'b1, 3'd1});
    fault0 = 0;
    run0(-1, cyc, ff, fl);
    check("rerun_fail_cleared", ff, 0);
    check("rerun_cycles", cyc, 161);
    check("rerun_clean", {if0.done, if0.fail, if0.fail_elem}, {1'b1, 1'b0, 3'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
